req_resp_monitor: RTL
=====================

# req_resp_monitor

Synthesizable checker for the "A implies eventually B" request/response rule: every cycle `a` is sampled high must be followed by `b` high 1 to TIMEOUT cycles later. It sits directly downstream of the A/B producer, in parallel with the simulation assertion, and turns the rule into hardware.
- Flags pass/fail per clock.
- Accumulates pass and fail counts.
- Records the worst observed latency, readable on silicon.

## Interface
Parameters:
- TIMEOUT, 16: maximum allowed cycles from `a` edge to `b` edge (≥1).
- CNT_W, 16: width of pass/fail counters and latency outputs.
- OUT_W, 8: width of outstanding-attempt counter.

Ports:
- clk  in  1  single clock; all sampling on posedge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  check enable; low acts as disable-iff (aborts pending attempts silently).
- a  in  1  trigger, synchronous to clk.
- b  in  1  response, synchronous to clk.
- pending  out  1  high while ≥1 attempt is outstanding.
- pass_pulse  out  1  one-cycle strobe, attempts satisfied at this edge.
- fail_pulse  out  1  one-cycle strobe, attempts timed out at this edge.
- wait_cnt  out  CNT_W  cycles elapsed since oldest outstanding `a`.
- pass_count  out  CNT_W  total passed attempts, saturating.
- fail_count  out  CNT_W  total failed attempts, saturating.
- max_latency  out  CNT_W  largest k (a-edge to b-edge) seen on a pass.

## Operation
- States: IDLE, WAIT. All outputs are registered.
- Reset values: state IDLE, every output 0, outstanding 0.
- **IDLE:**
  - en&&a: go to WAIT, outstanding=1, wait_cnt=0.
  - `b` alone: ignored.
- **WAIT**, each edge with en=1. Let k = wait_cnt+1.
  - **b=1 (pass):**
    - pass_pulse=1.
    - pass_count += outstanding.
    - max_latency = max(max_latency, k).
    - If a=1 at the same edge: that `a` is a new attempt not satisfied by this `b`; outstanding=1, wait_cnt=0, stay WAIT. Otherwise go to IDLE, outstanding=0, wait_cnt=0.
  - **b=0 and k==TIMEOUT (fail):**
    - fail_pulse=1.
    - fail_count += outstanding.
    - If a=1: new attempt, outstanding=1, wait_cnt=0, stay WAIT. Otherwise go to IDLE.
  - **b=0, k<TIMEOUT:**
    - wait_cnt=k.
    - If a=1: outstanding += 1, saturating at all-ones.
- All attempts outstanding at a given edge share the oldest attempt's timeout. An `a` arriving while pending can therefore fail early; this is intentional and documented.
- en=0 at an edge:
  - Go to IDLE, outstanding=0, wait_cnt=0.
  - No pulses; counters and max_latency hold.
  - An `a` on that edge is ignored.
- Arithmetic:
  - All counter additions saturate at 2^CNT_W−1 (and outstanding at 2^OUT_W−1); no wrap.
  - max_latency ≤ TIMEOUT always.

## Timing
- Pulses assert in the cycle after the deciding edge and last exactly one cycle.
- Counter outputs update on that same edge.
- Minimum pass latency k=1: `b` one edge after `a`. A `b` coincident with the triggering `a` does not count.
- Fail is declared at the edge where k reaches TIMEOUT with b=0. A `b` at k=TIMEOUT still passes.
- pass_pulse and fail_pulse are never high together.
- rst asserted mid-WAIT clears everything immediately (asynchronous). Deassertion takes effect at the next posedge.

## Structure
- Package `req_resp_monitor_pkg`:
  - state enum (IDLE, WAIT).
  - Saturating-add function, parameterized by width.
- Sub-module `sat_counter`:
  - Width param, increment value input, async active-high reset.
  - Used for pass_count and fail_count.
- Top level holds the FSM, wait_cnt, outstanding and max_latency.

## Test plan
- Reset released, a=1 at edge 1, b=1 at edge 4: one pass_pulse, pass_count=1, max_latency=3, pending low after edge 4.
- a=1 at edges 1, 2, 3; b=1 at edge 5: pass_count=3, max_latency=4, single pass_pulse.
- TIMEOUT=16, a=1 at edge 1, b held 0: fail_pulse after edge 17, fail_count=1. Repeat with b=1 at edge 17: pass instead, max_latency=16.
- a=1 and b=1 at the same edge while IDLE: no pass; a `b` at the next edge produces a pass with latency 1.
- a=1 at edge 1, en=0 at edge 3, b=1 at edge 4: no pulses, counts unchanged, pending low from edge 3.
- rst pulsed mid-WAIT with pass_count=5: all outputs 0 immediately. Force pass_count to all-ones, then pass again: count stays at all-ones.

Source files
------------

// File: rtl/req_resp_monitor_pkg.sv
// Shared types and helpers for the request/response rule checker.
package req_resp_monitor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Width-generic saturating add; callers cast the result back to their own width.
  function automatic logic [63:0] sat_add(input logic [63:0] x,
                                          input logic [63:0] y,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, x} + {1'b0, y};
    lim = (65'd1 << w) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating accumulator: adds a variable increment each clock, sticks at all-ones.
module sat_counter
  import req_resp_monitor_pkg::*;
#(
  parameter int W     = 16,
  parameter int INC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= W'(sat_add(64'(count), 64'(inc), W));
    end
  end

endmodule

// File: rtl/req_resp_monitor.sv
// Hardware checker for "a implies b within 1..TIMEOUT cycles": per-edge pass/fail
// strobes, saturating pass/fail totals and worst observed latency, all registered.
module req_resp_monitor
  import req_resp_monitor_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16,
  parameter int OUT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  output logic             pending,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic [CNT_W-1:0] wait_cnt,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] max_latency
);

  state_t           state;
  logic [OUT_W-1:0] outstanding;
  logic [CNT_W-1:0] k;
  logic             in_wait;
  logic             is_pass;
  logic             is_fail;
  logic [OUT_W-1:0] pass_inc;
  logic [OUT_W-1:0] fail_inc;

  // k is the latency this edge would have relative to the oldest open attempt.
  assign k        = wait_cnt + CNT_W'(1);
  assign in_wait  = en && (state == WAIT);
  assign is_pass  = in_wait && b;
  assign is_fail  = in_wait && !b && (k == CNT_W'(TIMEOUT));
  assign pass_inc = is_pass ? outstanding : '0;
  assign fail_inc = is_fail ? outstanding : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      outstanding <= '0;
      wait_cnt    <= '0;
      pending     <= 1'b0;
      pass_pulse  <= 1'b0;
      fail_pulse  <= 1'b0;
      max_latency <= '0;
    end else begin
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
      if (!en) begin
        // Disable aborts every open attempt without reporting it.
        state       <= IDLE;
        outstanding <= '0;
        wait_cnt    <= '0;
        pending     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (a) begin
              state       <= WAIT;
              outstanding <= OUT_W'(1);
              wait_cnt    <= '0;
              pending     <= 1'b1;
            end
          end
          WAIT: begin
            if (b || is_fail) begin
              pass_pulse <= b;
              fail_pulse <= !b;
              if (b && (k > max_latency)) begin
                max_latency <= k;
              end
              // A coincident a starts a fresh attempt that this edge cannot resolve.
              wait_cnt    <= '0;
              outstanding <= a ? OUT_W'(1) : '0;
              state       <= a ? WAIT : IDLE;
              pending     <= a;
            end else begin
              wait_cnt <= k;
              if (a) begin
                outstanding <= OUT_W'(sat_add(64'(outstanding), 64'd1, OUT_W));
              end
            end
          end
          default: begin
            state       <= IDLE;
            outstanding <= '0;
            wait_cnt    <= '0;
            pending     <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W), .INC_W(OUT_W)) u_pass_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pass_inc),
    .count (pass_count)
  );

  sat_counter #(.W(CNT_W), .INC_W(OUT_W)) u_fail_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (fail_inc),
    .count (fail_count)
  );

endmodule
